// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

  typedef logic [1:0] state_t;

  localparam state_t SCAN     = 2'd0;
  localparam state_t DEBOUNCE = 2'd1;
  localparam state_t PRESSED  = 2'd2;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Indexed by {row, col}; row 3 reads E 0 F D on the physical keypad.
  localparam logic [3:0] KEY_MAP [0:15] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones (idle rows).
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, debounce, key code with one-cycle valid strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 10000,
  parameter int unsigned DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]    row_sync;
  logic [PW-1:0] presc_q;
  logic          tick;
  state_t        state_q, state_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    col_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          cnt_done;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic          press;
  logic [1:0]    row_idx;
  logic [3:0]    code;

  sync_2ff #(
    .WIDTH(4)
  ) u_row_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (row),
    .q      (row_sync)
  );

  assign tick = (presc_q == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Lowest active row wins when several rows are pulled low together.
  always_comb begin
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) row_idx = 2'(r);
    end
  end

  assign press    = (row_sync != 4'hF);
  assign code     = KEY_MAP[{row_idx, col_idx_q}];
  assign cnt_inc  = (cnt_q == CW'(DEBOUNCE_SCANS)) ? cnt_q : cnt_q + 1'b1;
  assign cnt_done = (cnt_inc == CW'(DEBOUNCE_SCANS));

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    key_d     = key_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (press) begin
            cand_d  = code;
            cnt_d   = CW'(1);
            state_d = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (press && (code == cand_q)) begin
            if (cnt_done) begin
              key_d   = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = PRESSED;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end
        end
        PRESSED: begin
          if (press) begin
            cnt_d = '0;
          end else if (cnt_done) begin
            held_d    = 1'b0;
            cnt_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SCAN;
      col_idx_q <= 2'd0;
      col_q     <= COL_RESET;
      cnt_q     <= '0;
      cand_q    <= 4'h0;
      key_q     <= 4'h0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_drive(col_idx_d);
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign col       = col_q;
  assign key       = key_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad model and a key_valid scoreboard.
module tb_keypad_scanner;

  logic       clk;
  logic       reset_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;  // bit r*4+c set while key at row r, column c is down
  logic [3:0]  exp_q[$];
  int          vectors;
  int          miscompares;
  int          valid_seen;

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .row      (row),
    .col      (col),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Scoreboard monitor: every key_valid pulse must match the next queued key.
  always @(negedge clk) begin
    if (reset_n && key_valid) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(key), 32'hFFFF);
      end else begin
        check("valid_key", 32'(key), 32'(exp_q.pop_front()));
        check("valid_held", 32'(key_held), 32'd1);
      end
    end
  end

  task automatic wait_col(input logic [3:0] v, input bit eq, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((col == v) == eq) return;
    end
    timeout(name);
  endtask

  task automatic wait_drained(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) return;
    end
    timeout(name);
  endtask

  task automatic wait_released(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!key_held) return;
    end
    timeout(name);
  endtask

  initial begin
    logic [3:0] exp_col;
    vectors     = 0;
    miscompares = 0;
    valid_seen  = 0;
    pressed     = '0;
    reset_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", 32'(col), 32'hE);
    check("rst_key", 32'(key), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    reset_n = 1'b1;

    // 1: idle scan, four clocks per column
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("scan_col", 32'(col), 32'(exp_col));
      check("scan_valid", 32'(key_valid), 32'h0);
    end
    check("scan_key", 32'(key), 32'h0);
    check("scan_held", 32'(key_held), 32'h0);

    // 2: hold r1c2 -> key 6
    exp_q.push_back(4'h6);
    pressed[1*4+2] = 1'b1;
    wait_drained(60, "press_6");
    repeat (12) @(negedge clk);
    check("hold_col", 32'(col), 32'hB);
    check("hold_held", 32'(key_held), 32'h1);
    check("hold_key", 32'(key), 32'h6);

    // 4: short release, re-press, then a full release
    pressed = '0;
    repeat (8) @(negedge clk);
    check("short_rel_held", 32'(key_held), 32'h1);
    check("short_rel_col", 32'(col), 32'hB);
    pressed[1*4+2] = 1'b1;
    repeat (8) @(negedge clk);
    check("repress_held", 32'(key_held), 32'h1);
    pressed = '0;
    wait_released(40, "release_6");
    check("rel_col", 32'(col), 32'h7);
    check("rel_key", 32'(key), 32'h6);

    // 3: r0c0 for two ticks only -> rejected, scan resumes
    wait_col(4'hE, 1'b0, 20, "leave_c0_a");
    pressed[0] = 1'b1;
    wait_col(4'hE, 1'b1, 20, "enter_c0_a");
    repeat (8) @(negedge clk);
    check("bounce_frozen", 32'(col), 32'hE);
    pressed = '0;
    wait_col(4'hD, 1'b1, 8, "bounce_resume");
    check("bounce_key", 32'(key), 32'h6);
    check("bounce_held", 32'(key_held), 32'h0);

    // 5: r0c0 and r2c0 together -> lowest row, key 1
    exp_q.push_back(4'h1);
    pressed[0]     = 1'b1;
    pressed[2*4+0] = 1'b1;
    wait_drained(60, "press_1");
    pressed = '0;
    wait_released(40, "release_1");
    check("multi_key", 32'(key), 32'h1);

    // 6: asynchronous reset while debouncing
    wait_col(4'hE, 1'b0, 20, "leave_c0_b");
    pressed[0] = 1'b1;
    wait_col(4'hE, 1'b1, 20, "enter_c0_b");
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_col", 32'(col), 32'hE);
    check("arst_key", 32'(key), 32'h0);
    check("arst_valid", 32'(key_valid), 32'h0);
    check("arst_held", 32'(key_held), 32'h0);
    pressed = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_key", 32'(key), 32'h0);
    check("post_rst_held", 32'(key_held), 32'h0);

    check("valid_pulses", 32'(valid_seen), 32'd2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
